// File: rtl/alsu_pkg.sv
// Shared opcode constants and FSM encoding for the sequential ALU/shifter.
package alsu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_INC  = 4'd2;
  localparam logic [3:0] OP_DEC  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_NOT  = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_SAR  = 4'd10;
  localparam logic [3:0] OP_ROL  = 4'd11;
  localparam logic [3:0] OP_ROR  = 4'd12;
  localparam logic [3:0] OP_PASA = 4'd13;
  localparam logic [3:0] OP_PASB = 4'd14;
  localparam logic [3:0] OP_NEG  = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  function automatic logic is_shift(input logic [3:0] op);
    return (op >= OP_SHL) && (op <= OP_ROR);
  endfunction

endpackage

// File: rtl/alsu_comb.sv
// Single-cycle ALU ops with carry/borrow and signed overflow.
// Shift opcodes fall through to PASS A, which is the shift-by-zero result.
module alsu_comb
  import alsu_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [3:0]   func,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] res,
  output logic         cy,
  output logic         ov
);

  logic [W:0] sum;

  always_comb begin
    sum = '0;
    res = a;
    cy  = 1'b0;
    ov  = 1'b0;
    case (func)
      OP_ADD: begin
        sum = {1'b0, a} + {1'b0, b};
        res = sum[W-1:0];
        cy  = sum[W];
        ov  = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
      end
      // For subtracting ops the top bit of the W+1-bit result is the borrow.
      OP_SUB: begin
        sum = {1'b0, a} - {1'b0, b};
        res = sum[W-1:0];
        cy  = sum[W];
        ov  = (a[W-1] != b[W-1]) && (res[W-1] != a[W-1]);
      end
      OP_INC: begin
        sum = {1'b0, a} + (W+1)'(1);
        res = sum[W-1:0];
        cy  = sum[W];
        ov  = ~a[W-1] & res[W-1];
      end
      OP_DEC: begin
        sum = {1'b0, a} - (W+1)'(1);
        res = sum[W-1:0];
        cy  = sum[W];
        ov  = a[W-1] & ~res[W-1];
      end
      OP_NEG: begin
        sum = {(W+1){1'b0}} - {1'b0, a};
        res = sum[W-1:0];
        cy  = sum[W];
        ov  = a[W-1] & res[W-1];
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NOT:  res = ~a;
      OP_PASB: res = b;
      default: res = a;
    endcase
  end

endmodule

// File: rtl/alsu_seq.sv
// Sequential ALU: single-cycle ops finish in one cycle, shifts/rotates
// move the working register one bit per cycle under a down-counter.
module alsu_seq
  import alsu_pkg::*;
#(
  parameter  int W  = 16,
  localparam int SW = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [3:0]   funcion,
  input  logic [W-1:0] tupla_a,
  input  logic [W-1:0] tupla_b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] respuesta,
  output logic         cy,
  output logic         ov,
  output logic         z,
  output logic         n
);

  state_t        state, state_nxt;
  logic [3:0]    op;
  logic [W-1:0]  work, work_nxt;
  logic          bit_out;
  logic [SW-1:0] cnt;
  logic [SW-1:0] amt;
  logic          shift_req;
  logic [W-1:0]  c_res;
  logic          c_cy, c_ov;

  assign amt       = tupla_b[SW-1:0];
  assign shift_req = is_shift(funcion) && (amt != '0);

  alsu_comb #(.W(W)) u_comb (
    .func (funcion),
    .a    (tupla_a),
    .b    (tupla_b),
    .res  (c_res),
    .cy   (c_cy),
    .ov   (c_ov)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    case (state)
      S_IDLE:  if (start) state_nxt = shift_req ? S_SHIFT : S_DONE;
      S_SHIFT: if (cnt == SW'(1)) state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // One-bit step of the latched shift op; bit_out is the bit leaving the word.
  always_comb begin
    work_nxt = work;
    bit_out  = 1'b0;
    case (op)
      OP_SHL: {bit_out, work_nxt} = {work, 1'b0};
      OP_SHR: {work_nxt, bit_out} = {1'b0, work};
      OP_SAR: {work_nxt, bit_out} = {work[W-1], work};
      OP_ROL: begin
        work_nxt = {work[W-2:0], work[W-1]};
        bit_out  = work[W-1];
      end
      OP_ROR: begin
        work_nxt = {work[0], work[W-1:1]};
        bit_out  = work[0];
      end
      default: ;
    endcase
  end

  // Results are written on the edge that enters DONE, so they stay stable
  // from one done pulse to the next.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op        <= '0;
      work      <= '0;
      cnt       <= '0;
      respuesta <= '0;
      cy        <= 1'b0;
      ov        <= 1'b0;
      z         <= 1'b0;
      n         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          op   <= funcion;
          work <= tupla_a;
          cnt  <= shift_req ? amt : '0;
          if (!shift_req) begin
            respuesta <= c_res;
            cy        <= c_cy;
            ov        <= c_ov;
            z         <= (c_res == '0);
            n         <= c_res[W-1];
          end
        end
        S_SHIFT: begin
          work <= work_nxt;
          cnt  <= cnt - SW'(1);
          if (cnt == SW'(1)) begin
            respuesta <= work_nxt;
            cy        <= bit_out;
            ov        <= 1'b0;
            z         <= (work_nxt == '0);
            n         <= work_nxt[W-1];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alsu_seq.sv
// Bench for alsu_seq: directed vector table, randomized ops against an
// arithmetic reference model, and busy/reset corner sequences.
module tb_alsu_seq;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   funcion;
  logic [W-1:0] tupla_a, tupla_b;
  logic         busy, done, cy, ov, z, n;
  logic [W-1:0] respuesta;

  int passes = 0;
  int total  = 0;

  alsu_seq #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .funcion(funcion),
    .tupla_a(tupla_a), .tupla_b(tupla_b), .busy(busy), .done(done),
    .respuesta(respuesta), .cy(cy), .ov(ov), .z(z), .n(n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a, b, res;
    logic         cy, ov;
    int           lat;
  } vec_t;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic bit in_range(input int x);
    return (x >= -(1 << (W-1))) && (x < (1 << (W-1)));
  endfunction

  // Reference behaviour from plain integer arithmetic.
  function automatic void model(input logic [3:0] op, input logic [W-1:0] a, b,
                                output logic [W-1:0] r, output logic c, o);
    int ua, ub, sa, sb, k, t;
    ua = int'(a); ub = int'(b);
    sa = a[W-1] ? ua - (1 << W) : ua;
    sb = b[W-1] ? ub - (1 << W) : ub;
    k  = ub % W;
    c = 1'b0; o = 1'b0; r = a;
    case (op)
      4'd0:  begin t = ua + ub; r = W'(t); c = t >= (1 << W); o = !in_range(sa + sb); end
      4'd1:  begin r = W'(ua - ub); c = ua < ub; o = !in_range(sa - sb); end
      4'd2:  begin t = ua + 1; r = W'(t); c = t >= (1 << W); o = !in_range(sa + 1); end
      4'd3:  begin r = W'(ua - 1); c = ua < 1; o = !in_range(sa - 1); end
      4'd4:  r = a & b;
      4'd5:  r = a | b;
      4'd6:  r = a ^ b;
      4'd7:  r = ~a;
      4'd8:  begin r = W'(ua << k); c = (k != 0) && (((ua >> (W - k)) & 1) != 0); end
      4'd9:  begin r = W'(ua >> k); c = (k != 0) && (((ua >> (k - 1)) & 1) != 0); end
      4'd10: begin r = W'(sa >>> k); c = (k != 0) && (((ua >> (k - 1)) & 1) != 0); end
      4'd11: begin r = W'((ua << k) | (ua >> (W - k))); c = (k != 0) && r[0]; end
      4'd12: begin r = W'((ua >> k) | (ua << (W - k))); c = (k != 0) && r[W-1]; end
      4'd13: r = a;
      4'd14: r = b;
      default: begin r = W'(-ua); c = ua != 0; o = !in_range(-sa); end
    endcase
  endfunction

  // Issue one request and wait (bounded) for done. If inj>0, a stray ADD
  // start is raised in that cycle after acceptance.
  task automatic run(input logic [3:0] op, input logic [W-1:0] a, b, input int inj,
                     output logic [W-1:0] r, output logic c, o, zz, nn,
                     output int lat, output bit busy_ok, output bit got);
    @(negedge clk);
    start = 1'b1; funcion = op; tupla_a = a; tupla_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    funcion = 4'($urandom); tupla_a = W'($urandom); tupla_b = W'($urandom);
    lat = 0; busy_ok = 1'b1; got = 1'b0;
    while (!got && lat < 40) begin
      lat++;
      if (!busy) busy_ok = 1'b0;
      if (done) got = 1'b1;
      else begin
        if (lat == inj) begin start = 1'b1; funcion = 4'd0; end
        else start = 1'b0;
        @(posedge clk); #1;
      end
    end
    r = respuesta; c = cy; o = ov; zz = z; nn = n;
    start = 1'b0;
    if (!got) begin
      total++;
      $display("FAIL timeout: op %0d got no done, expected done", op);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_op(input string tag, input logic [3:0] op, input logic [W-1:0] a, b,
                          input int inj, input logic [W-1:0] er, input logic ec, eo,
                          input int elat);
    logic [W-1:0] r; logic c, o, zz, nn; int lat; bit bok, got;
    run(op, a, b, inj, r, c, o, zz, nn, lat, bok, got);
    if (got) begin
      chk({tag, ".res"}, r, er);
      chk({tag, ".cy"}, W'(c), W'(ec));
      chk({tag, ".ov"}, W'(o), W'(eo));
      chk({tag, ".z"}, W'(zz), W'(er == '0));
      chk({tag, ".n"}, W'(nn), W'(er[W-1]));
      chk({tag, ".lat"}, W'(lat), W'(elat));
      chk({tag, ".busy"}, W'(bok), W'(1));
    end
  endtask

  vec_t vecs[$];

  initial begin
    logic [W-1:0] er, a, b; logic ec, eo; int k, elat; bit seen;
    logic [3:0] op;

    vecs = '{
      '{4'd0,  16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1},
      '{4'd0,  16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1},
      '{4'd15, 16'h8000, 16'h0000, 16'h8000, 1'b1, 1'b1, 1},
      '{4'd8,  16'h8001, 16'h0003, 16'h0008, 1'b0, 1'b0, 4},
      '{4'd12, 16'h0001, 16'h0001, 16'h8000, 1'b1, 1'b0, 2},
      '{4'd10, 16'h8000, 16'h000F, 16'hFFFF, 1'b0, 1'b0, 16},
      '{4'd1,  16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1},
      '{4'd1,  16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1},
      '{4'd3,  16'h0000, 16'h1234, 16'hFFFF, 1'b1, 1'b0, 1},
      '{4'd2,  16'h7FFF, 16'h0000, 16'h8000, 1'b0, 1'b1, 1},
      '{4'd8,  16'h1234, 16'h0010, 16'h1234, 1'b0, 1'b0, 1},
      '{4'd11, 16'h8000, 16'h000F, 16'h4000, 1'b0, 1'b0, 16},
      '{4'd6,  16'hF0F0, 16'hFF00, 16'h0FF0, 1'b0, 1'b0, 1},
      '{4'd7,  16'h0000, 16'h5555, 16'hFFFF, 1'b0, 1'b0, 1},
      '{4'd14, 16'h1111, 16'h8421, 16'h8421, 1'b0, 1'b0, 1},
      '{4'd9,  16'h0003, 16'h0001, 16'h0001, 1'b1, 1'b0, 2}
    };

    rst = 1'b1; start = 1'b0; funcion = '0; tupla_a = '0; tupla_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.res", respuesta, '0);
    chk("reset.flags", W'({busy, done, cy, ov, z, n}), '0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      check_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 0,
               vecs[i].res, vecs[i].cy, vecs[i].ov, vecs[i].lat);

    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom); a = W'($urandom); b = W'($urandom);
      if ($urandom_range(0, 3) == 0) b[3:0] = 4'd0;
      model(op, a, b, er, ec, eo);
      k = int'(b[3:0]);
      elat = (op >= 4'd8 && op <= 4'd12 && k != 0) ? k + 1 : 1;
      check_op($sformatf("rnd%0d", i), op, a, b, 0, er, ec, eo, elat);
    end

    // Stray start during a shift must be ignored and produce no extra done.
    check_op("busy_start", 4'd9, 16'hFFFF, 16'h0008, 3, 16'h00FF, 1'b1, 1'b0, 9);
    seen = 1'b0;
    repeat (5) begin @(posedge clk); #1; if (done) seen = 1'b1; end
    chk("busy_start.no_extra_done", W'(seen), '0);

    // Reset in the middle of a shift aborts it.
    check_op("pre_rst", 4'd0, 16'h0001, 16'h0001, 0, 16'h0002, 1'b0, 1'b0, 1);
    @(negedge clk);
    start = 1'b1; funcion = 4'd8; tupla_a = 16'h0001; tupla_b = 16'h000A;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst.res", respuesta, '0);
    chk("mid_rst.flags", W'({busy, done, cy, ov, z, n}), '0);
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    repeat (15) begin @(posedge clk); #1; if (done || busy) seen = 1'b1; end
    chk("mid_rst.no_done", W'(seen), '0);
    check_op("post_rst", 4'd0, 16'h0002, 16'h0003, 0, 16'h0005, 1'b0, 1'b0, 1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/alsu_seq.md
ALSU_SEQ -- requirements
Module: alsu_seq

Interface
REQ-001 Parameter W, default 16, operand/result width; legal values 4..64, power of two.
REQ-002 Parameter SW, default $clog2(W), shift-amount width; derived, not overridden.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request; sampled only while busy=0.
REQ-006 funcion  input  4  operation code, captured with start.
REQ-007 tupla_a  input  W  operand A, captured with start.
REQ-008 tupla_b  input  W  operand B, captured with start; shift ops use tupla_b[SW-1:0] as amount.
REQ-009 busy  output  1  high from the accepting edge until done is asserted.
REQ-010 done  output  1  one-cycle pulse: respuesta and flags are valid.
REQ-011 respuesta  output  W  registered result, held until the next done.
REQ-012 cy, ov, z, n  output  1 each  registered carry, signed overflow, zero, sign flags, held with respuesta.

Function
REQ-013 Opcodes: 0 ADD, 1 SUB (A-B), 2 INC A, 3 DEC A, 4 AND, 5 OR, 6 XOR, 7 NOT A, 8 SHL, 9 SHR logical, 10 SAR, 11 ROL, 12 ROR, 13 PASS A, 14 PASS B, 15 NEG A (two's complement).
REQ-014 FSM states IDLE, SHIFT, DONE: IDLE->DONE on start with ops 0-7, 13-15, or with ops 8-12 and amount 0; IDLE->SHIFT on start with ops 8-12 and amount>0; SHIFT->DONE when the remaining count reaches 0; DONE->IDLE unconditionally.
REQ-015 done is high exactly in the DONE state; busy is high in SHIFT and DONE.
REQ-016 Latency: non-shift op, or shift by 0: done 1 cycle after the accepting edge; shift by k>0: done k+1 cycles after it.
REQ-017 SHIFT moves the working register exactly one bit per cycle and decrements a SW-bit counter.
REQ-018 Arithmetic uses a W+1-bit sum: ADD/INC cy = carry out; SUB/DEC/NEG cy = borrow (1 when unsigned A<B, A=0 for DEC, A!=0 for NEG).
REQ-019 ov = signed overflow for ops 0-3 and 15 (NEG of 100..0 sets ov=1); ov=0 for all other ops.
REQ-020 Shift ops: cy = last bit shifted or rotated out; shift by 0 gives cy=0 and respuesta=A.
REQ-021 Logic and pass ops: cy=0, ov=0.
REQ-022 z = (respuesta==0) and n = respuesta[W-1], for every op.
REQ-023 start while busy=1 is ignored; operands and function are not re-captured.
REQ-024 start in the DONE cycle is ignored; a new request is accepted no earlier than the following IDLE cycle.
REQ-025 Input changes after the accepting edge have no effect on the operation in progress.

Reset
REQ-026 rst=1 forces IDLE, busy=0, done=0, respuesta=0, cy=ov=z=n=0, and shift counter=0, independent of clk.
REQ-027 Reset during SHIFT aborts the operation; no done pulse is produced for it after release.
REQ-028 The first accepted start is on the first rising edge with rst=0 and start=1.

Structure
REQ-029 Package alsu_pkg holds the 4-bit opcode constants and the FSM state encoding.
REQ-030 Sub-module alsu_comb (parameter W) computes the single-cycle ops and their flags combinationally; alsu_seq holds the FSM, operand registers, shifter and counter.

Verification (W=16)
REQ-031 ADD A=FFFF B=0001 -> done after 1 cycle, respuesta=0000, cy=1, ov=0, z=1, n=0.
REQ-032 ADD A=7FFF B=0001 -> respuesta=8000, cy=0, ov=1, n=1; NEG A=8000 -> respuesta=8000, ov=1.
REQ-033 SHL A=8001 B=0003 -> busy for 4 cycles, done on the 4th cycle after acceptance, respuesta=0008, cy=0.
REQ-034 ROR A=0001 B=0001 -> respuesta=8000, cy=1; SAR A=8000 B=000F -> respuesta=FFFF, done 16 cycles after acceptance.
REQ-035 SHR A=FFFF B=0008, with start pulsed again with ADD at cycle 3 -> ADD ignored, respuesta=00FF, cy=1.
REQ-036 SHL A=0001 B=000A, rst asserted at cycle 4 for 1 cycle -> all outputs 0 immediately, no done pulse afterward, next ADD 0002+0003 returns 0005.
